bv2_masked_delta: RTL and testbench

Masked, pipelined GF(2^2) delta stage of the tower-field S-box GF(2^4) inverter. For a GF(2^4) element split into high/low GF(2^2) halves h, l, it computes delta = sigma^2·(h⊕l)^2 ⊕ h·l in d-share DOM form. The output feeds the GF(2^2) inverter. The block has one register stage and a valid/ready handshake, so the inverter pipeline can stall it.

---
 rtl/bv2_masked_delta.sv | 103 ++++++++++
 tb/tb_bv2_masked_delta.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bv2_masked_delta.sv
// bv2_masked_delta: d-share DOM GF(2^2) delta = W*(h^l)^2 ^ h*l, feeding the GF(2^2) inverter.
// Latency: one cycle from the accept edge to out_valid; one transfer per cycle while out_ready is high.
// Backpressure: in_ready = ~out_valid | out_ready; a stalled stage holds its shares and ignores in_random.
module bv2_masked_delta #(
  parameter  int NUM_SHARES = 2,
  localparam int NUM_RANDOM = NUM_SHARES * (NUM_SHARES - 1) / 2
) (
  input  logic                        in_clock,
  input  logic                        in_reset,
  input  logic [NUM_SHARES-1:0][1:0]  in_h,
  input  logic [NUM_SHARES-1:0][1:0]  in_l,
  input  logic [NUM_RANDOM-1:0][1:0]  in_random,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [NUM_SHARES-1:0][1:0]  out_delta,
  output logic                        out_valid,
  input  logic                        out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state_q, state_d;
  logic   accept;

  logic [NUM_SHARES-1:0][1:0]                 a_d, a_q;
  logic [NUM_SHARES-1:0][NUM_SHARES-1:0][1:0] q_d, q_q;

  // Squaring in a normal basis swaps the two coordinates.
  function automatic logic [1:0] gf_sq(input logic [1:0] x);
    return {x[0], x[1]};
  endfunction

  // Multiply by sigma^2 = W.
  function automatic logic [1:0] gf_scl(input logic [1:0] x);
    return {x[0] ^ x[1], x[1]};
  endfunction

  function automatic logic [1:0] gf_mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {e ^ (a[1] & b[1]), e ^ (a[0] & b[0])};
  endfunction

  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == FULL);
  assign in_ready  = ~out_valid | out_ready;

  // Per-share terms: the linear part folds into the inner product; each cross
  // term gets its own register so no two shares meet before the flop.
  for (genvar i = 0; i < NUM_SHARES; i++) begin : g_share
    assign a_d[i] = gf_mul(in_h[i], in_l[i]) ^ gf_scl(gf_sq(in_h[i] ^ in_l[i]));
    for (genvar j = 0; j < NUM_SHARES; j++) begin : g_pair
      if (i == j) begin : g_diag
        assign q_d[i][j] = 2'b00;
      end else begin : g_cross
        localparam int LO   = (i < j) ? i : j;
        localparam int HI   = (i < j) ? j : i;
        // Lexicographic position of pair (LO,HI) among all pairs LO<HI.
        localparam int RIDX = LO * (2 * NUM_SHARES - LO - 1) / 2 + (HI - LO - 1);
        assign q_d[i][j] = gf_mul(in_h[i], in_l[j]) ^ in_random[RIDX];
      end
    end
  end

  // Valid-flag register.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) state_q <= EMPTY;
    else          state_q <= state_d;
  end

  // Next-state: fill on accept, drain when downstream takes the data and nothing new arrives.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (!accept && out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Share registers load only on accept so idle cycles cause no toggling.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      a_q <= '0;
      q_q <= '0;
    end else if (accept) begin
      a_q <= a_d;
      q_q <= q_d;
    end
  end

  // Post-register compression; diagonal slots are tied to zero and fold away.
  always_comb begin
    out_delta = '0;
    for (int i = 0; i < NUM_SHARES; i++) begin
      out_delta[i] = a_q[i];
      for (int j = 0; j < NUM_SHARES; j++) begin
        out_delta[i] = out_delta[i] ^ q_q[i][j];
      end
    end
  end

endmodule

// File: tb/tb_bv2_masked_delta.sv
// Testbench for bv2_masked_delta: d=2 scoreboard run plus direct d=3/d=4 sweeps.
// Expected deltas come from the table and an unmasked GF(2^2) reference.
// A negedge monitor pops the scoreboard on every out_valid & out_ready.
module tb_bv2_masked_delta;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [1:0][1:0] h2, l2, d2;
  logic [0:0][1:0] r2;
  logic            v2, ir2, ov2, or2;

  logic [2:0][1:0] h3, l3, r3, d3;
  logic            v3, ir3, ov3, or3;

  logic [3:0][1:0] h4, l4, d4;
  logic [5:0][1:0] r4;
  logic            v4, ir4, ov4, or4;

  bv2_masked_delta #(.NUM_SHARES(2)) dut2 (
    .in_clock(clk), .in_reset(rst), .in_h(h2), .in_l(l2), .in_random(r2),
    .in_valid(v2), .in_ready(ir2), .out_delta(d2), .out_valid(ov2), .out_ready(or2));

  bv2_masked_delta #(.NUM_SHARES(3)) dut3 (
    .in_clock(clk), .in_reset(rst), .in_h(h3), .in_l(l3), .in_random(r3),
    .in_valid(v3), .in_ready(ir3), .out_delta(d3), .out_valid(ov3), .out_ready(or3));

  bv2_masked_delta #(.NUM_SHARES(4)) dut4 (
    .in_clock(clk), .in_reset(rst), .in_h(h4), .in_l(l4), .in_random(r4),
    .in_valid(v4), .in_ready(ir4), .out_delta(d4), .out_valid(ov4), .out_ready(or4));

  typedef struct packed {
    logic [1:0] h;
    logic [1:0] l;
    logic [1:0] d;
  } vec_t;

  vec_t       tbl [7];
  logic [1:0] exp_q [$];
  int         n_cmp;
  int         n_fail;
  bit         rand_rdy;

  // Unmasked reference: lin = W*(h^l)^2 written out per coordinate, plus h*l.
  function automatic logic [1:0] ref_delta(input logic [1:0] h, input logic [1:0] l);
    logic [1:0] s, lin, prod;
    logic       e;
    s    = h ^ l;
    lin  = {s[0] ^ s[1], s[0]};
    e    = (h[1] ^ h[0]) & (l[1] ^ l[0]);
    prod = {e ^ (h[1] & l[1]), e ^ (h[0] & l[0])};
    return lin ^ prod;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one masked transfer into the d=2 instance and queue its expected delta.
  task automatic send2(input logic [1:0] h, input logic [1:0] l, input logic [1:0] e);
    int n;
    h2[0] = 2'($urandom);
    h2[1] = h2[0] ^ h;
    l2[0] = 2'($urandom);
    l2[1] = l2[0] ^ l;
    r2[0] = 2'($urandom);
    v2    = 1'b1;
    n     = 0;
    @(negedge clk);
    while (!ir2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir2) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: in_ready still 0 after %0d cycles, expected 1", n);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    v2 = 1'b0;
  endtask

  // Random downstream readiness for the d=2 instance.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) or2 = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard monitor plus stall-hold check, sampled mid-cycle.
  initial begin
    logic            stall_prev;
    logic [1:0][1:0] d_prev;
    logic [1:0]      e;
    stall_prev = 1'b0;
    d_prev     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("stall_valid", 32'(ov2), 32'd1);
          chk("stall_hold", 32'(d2), 32'(d_prev));
        end
        if (ov2 && or2) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_underflow: got output %0h, expected no output", d2[0] ^ d2[1]);
          end else begin
            e = exp_q.pop_front();
            chk("sb_delta", 32'(d2[0] ^ d2[1]), 32'(e));
          end
        end
        stall_prev = ov2 && !or2;
        d_prev     = d2;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0][1:0] held;
    logic [1:0]      idle_exp, acc3, acc4;
    logic [3:0]      hv;

    tbl[0] = '{h: 2'b01, l: 2'b10, d: 2'b10};
    tbl[1] = '{h: 2'b11, l: 2'b11, d: 2'b11};
    tbl[2] = '{h: 2'b00, l: 2'b01, d: 2'b11};
    tbl[3] = '{h: 2'b00, l: 2'b00, d: 2'b00};
    tbl[4] = '{h: 2'b01, l: 2'b01, d: 2'b10};
    tbl[5] = '{h: 2'b10, l: 2'b10, d: 2'b01};
    tbl[6] = '{h: 2'b10, l: 2'b01, d: 2'b10};

    n_cmp = 0; n_fail = 0; rand_rdy = 1'b0;
    rst = 1'b1;
    h2 = '0; l2 = '0; r2 = '0; v2 = 1'b0; or2 = 1'b1;
    h3 = '0; l3 = '0; r3 = '0; v3 = 1'b0; or3 = 1'b1;
    h4 = '0; l4 = '0; r4 = '0; v4 = 1'b0; or4 = 1'b1;

    // Reset state.
    #3;
    chk("rst_valid", 32'(ov2), 32'd0);
    chk("rst_ready", 32'(ir2), 32'd1);
    chk("rst_delta", 32'(d2), 32'd0);
    chk("rst_valid_d3", 32'(ov3), 32'd0);
    chk("rst_delta_d4", 32'(d4), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Unmasked first transfer with one-cycle latency.
    h2[0] = 2'b01; h2[1] = 2'b00; l2[0] = 2'b10; l2[1] = 2'b00; r2[0] = 2'b00;
    v2 = 1'b1;
    @(negedge clk);
    chk("first_ready", 32'(ir2), 32'd1);
    exp_q.push_back(2'b10);
    @(posedge clk);
    #1;
    v2 = 1'b0;
    chk("lat_valid", 32'(ov2), 32'd1);
    chk("lat_delta", 32'(d2[0] ^ d2[1]), 32'd2);

    // Table vectors, back to back.
    for (int k = 0; k < 7; k++) send2(tbl[k].h, tbl[k].l, tbl[k].d);

    // All 16 pairs, 100 maskings each, random downstream stalls.
    rand_rdy = 1'b1;
    for (int hl = 0; hl < 16; hl++) begin
      hv = 4'(hl);
      for (int m = 0; m < 100; m++) send2(hv[3:2], hv[1:0], ref_delta(hv[3:2], hv[1:0]));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #1;
    or2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: FULL with a stalled downstream, then drain+accept on one edge.
    or2 = 1'b0;
    send2(2'b11, 2'b11, 2'b11);
    h2[0] = 2'($urandom); h2[1] = h2[0];
    l2[0] = 2'($urandom); l2[1] = l2[0] ^ 2'b01;
    v2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(ir2), 32'd0);
      chk("bp_valid", 32'(ov2), 32'd1);
      chk("bp_delta", 32'(d2[0] ^ d2[1]), 32'd3);
      @(posedge clk);
      #1;
      r2[0] = 2'($urandom);
    end
    or2 = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(ir2), 32'd1);
    exp_q.push_back(2'b11);
    @(posedge clk);
    #1;
    v2 = 1'b0;
    chk("bp_refill_valid", 32'(ov2), 32'd1);
    chk("bp_refill_delta", 32'(d2[0] ^ d2[1]), 32'd3);
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset while FULL, between edges.
    or2 = 1'b0;
    send2(2'b01, 2'b10, 2'b10);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(ov2), 32'd0);
    chk("arst_delta", 32'(d2), 32'd0);
    chk("arst_ready", 32'(ir2), 32'd1);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    or2 = 1'b1;
    send2(2'b11, 2'b01, ref_delta(2'b11, 2'b01));
    chk("post_rst_valid", 32'(ov2), 32'd1);
    chk("post_rst_delta", 32'(d2[0] ^ d2[1]), 32'(ref_delta(2'b11, 2'b01)));

    // Idle: inputs toggle without in_valid; share registers must not move.
    @(posedge clk);
    #1;
    @(negedge clk);
    held     = d2;
    idle_exp = ref_delta(2'b11, 2'b01);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      r2[0] = 2'($urandom);
      h2    = 4'($urandom);
      l2    = 4'($urandom);
      @(negedge clk);
      chk("idle_valid", 32'(ov2), 32'd0);
      chk("idle_hold", 32'(d2), 32'(held));
      chk("idle_delta", 32'(d2[0] ^ d2[1]), 32'(idle_exp));
    end
    @(posedge clk);
    #1;

    // d=3 and d=4 instances: all 16 pairs with several random maskings.
    for (int hl = 0; hl < 16; hl++) begin
      hv = 4'(hl);
      for (int m = 0; m < 4; m++) begin
        h3[0] = 2'($urandom); h3[1] = 2'($urandom); h3[2] = hv[3:2] ^ h3[0] ^ h3[1];
        l3[0] = 2'($urandom); l3[1] = 2'($urandom); l3[2] = hv[1:0] ^ l3[0] ^ l3[1];
        r3    = 6'($urandom);
        h4[0] = 2'($urandom); h4[1] = 2'($urandom); h4[2] = 2'($urandom);
        h4[3] = hv[3:2] ^ h4[0] ^ h4[1] ^ h4[2];
        l4[0] = 2'($urandom); l4[1] = 2'($urandom); l4[2] = 2'($urandom);
        l4[3] = hv[1:0] ^ l4[0] ^ l4[1] ^ l4[2];
        r4    = 12'($urandom);
        v3 = 1'b1;
        v4 = 1'b1;
        @(negedge clk);
        chk("d3_ready", 32'(ir3), 32'd1);
        chk("d4_ready", 32'(ir4), 32'd1);
        @(posedge clk);
        #1;
        v3 = 1'b0;
        v4 = 1'b0;
        acc3 = d3[0] ^ d3[1] ^ d3[2];
        acc4 = d4[0] ^ d4[1] ^ d4[2] ^ d4[3];
        chk("d3_valid", 32'(ov3), 32'd1);
        chk("d4_valid", 32'(ov4), 32'd1);
        chk("d3_delta", 32'(acc3), 32'(ref_delta(hv[3:2], hv[1:0])));
        chk("d4_delta", 32'(acc4), 32'(ref_delta(hv[3:2], hv[1:0])));
      end
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
